operand_fetch: RTL and testbench
================================

# operand_fetch

Parametrised register-read stage for the RV32 pipeline, sitting between instruction decode and the ALU. It holds the architectural register file, generates the sign-extended immediate, and forwards operands from EX and WB. It detects load-use hazards and stalls upstream, and re-snoops WB while its output is held. A valid/ready handshake is used on both sides, with a synchronous flush for branch redirects.

## Interface
Parameters:
- XLEN, 32, datapath width (≥32)
- NREG, 32, register count (power of two, ≥2); RIDX = log2(NREG)
- NOP_INSN, 32'h00000033, instruction emitted on flush/reset

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  branch redirect; kills held and incoming instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts in_insn this cycle
- in_insn  in  32  instruction
- in_pc  in  XLEN  instruction PC
- ex_wen / ex_rd / ex_val / ex_is_load  in  1/RIDX/XLEN/1  EX-stage result; ex_is_load = value not yet available
- wb_wen / wb_rd / wb_val  in  1/RIDX/XLEN  writeback port
- out_valid  out  1  output holds a valid instruction
- out_ready  in  1  downstream accepts
- out_insn  out  32; out_pc  out  XLEN
- out_rs1_val, out_rs2_val, out_imm  out  XLEN  operands, sign-extended immediate
- stall_cnt  out  32  load-use stall cycles, saturating

## Operation
- Register file: NREG×XLEN. Write on posedge when wb_wen && wb_rd≠0. Entry 0 always reads 0. Reads are combinational with write-through: same-cycle wb to the read index returns wb_val.
- Fields: rs1 = insn[19:15], rs2 = insn[24:20], truncated to RIDX bits. Any field with bits above RIDX set reads as 0.
- Source use by opcode:
  - rs1 used: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2 used: 0110011, 0100011, 1100011.
  - LUI (0110111), AUIPC (0010111), JAL (1101111) use neither.
- Operand select per source, first match wins:
  - index 0 or unused → 0
  - ex_wen && ex_rd==rs && !ex_is_load → ex_val
  - wb_wen && wb_rd==rs → wb_val
  - register file
- Hazard = ex_wen && ex_is_load && ex_rd≠0 && ex_rd equals a used source of in_insn.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Capture (in_valid && in_ready): register insn, pc, forwarded operands, immediate; out_valid←1.
- Drain: out_valid && out_ready && no capture → out_valid←0, out_insn←NOP_INSN.
- Hold (out_valid && !out_ready): each held operand whose source was used and nonzero takes wb_val when wb_wen && wb_rd matches. EX is not snooped while holding.
- Immediate by opcode, sign-extended from bit 31 to XLEN:
  - I (0010011, 0000011, 1100111): insn[31:20].
  - S: {insn[31:25], insn[11:7]}.
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
  - U (LUI/AUIPC): {insn[31:12], 12'b0}.
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
  - R and others: 0.
- stall_cnt increments on every cycle with in_valid && hazard && !flush; it holds at 0xFFFFFFFF.

## Timing
- Latency 1: instruction captured at edge N is on the outputs after edge N.
- Throughput 1/cycle with out_ready held high.
- Flush, registered at the next edge, has priority over everything:
  - out_valid←0, out_insn←NOP_INSN; incoming instruction dropped.
  - The register-file write still occurs.
  - stall_cnt is not incremented.
- Drain and capture in the same cycle: the new instruction replaces the old, out_valid stays 1.
- Hazard persists while the load is in EX. When the load reaches WB, hazard clears and the value is forwarded via wb.
- Reset (priority over flush), values after the edge:
  - all registers 0; out_valid 0; out_insn NOP_INSN; out_pc, operands, out_imm 0; stall_cnt 0.
  - in_ready is 0 during the reset cycle.
  - Reset mid-operation discards the held instruction.

## Test plan
- Reset, then wb writes x5=0x1234; next cycle issue `add x6,x5,x0` (0x00028333) → out_rs1_val=0x1234, out_rs2_val=0, out_imm=0, out_valid=1 one cycle later.
- EX ex_rd=5, ex_val=0xAAAA, WB wb_rd=5, wb_val=0xBBBB in the same cycle, issue `addi x7,x5,-1` (0xFFF28393) → out_rs1_val=0xAAAA, out_imm=0xFFFFFFFF.
- ex_is_load=1, ex_rd=5, issue `sw x5,8(x2)` for 2 cycles → in_ready=0, stall_cnt=2. Next cycle wb_rd=5, wb_val=0x55 → captured out_rs2_val=0x55, out_imm=8.
- Capture x5 operand with out_ready=0, then wb writes x5=0x99 → held out_rs1_val becomes 0x99; out_ready=1 drains.
- flush asserted with in_valid=1 and out_valid=1 → next cycle out_valid=0, out_insn=0x00000033, no capture. Write `lui x1` (0x123450B7) afterwards → out_imm=0x12345000.
- NREG=16, `add x1,x17,x0` (0x000880B3) → out_rs1_val=0. Write to x0 then read x0 → 0.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Bundle between decode, EX/WB feedback and the ALU side of the operand
// fetch stage. The master drives the stage inputs; the stage is the slave.
interface operand_fetch_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            ex_wen;
  logic [RIDX-1:0] ex_rd;
  logic [XLEN-1:0] ex_val;
  logic            ex_is_load;
  logic            wb_wen;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_val;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_insn;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [XLEN-1:0] out_imm;
  logic [31:0]     stall_cnt;

  modport master (
    output flush, in_valid, in_insn, in_pc,
    output ex_wen, ex_rd, ex_val, ex_is_load,
    output wb_wen, wb_rd, wb_val, out_ready,
    input  in_ready, out_valid, out_insn, out_pc,
    input  out_rs1_val, out_rs2_val, out_imm, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_insn, in_pc,
    input  ex_wen, ex_rd, ex_val, ex_is_load,
    input  wb_wen, wb_rd, wb_val, out_ready,
    output in_ready, out_valid, out_insn, out_pc,
    output out_rs1_val, out_rs2_val, out_imm, stall_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// RV32 register-read stage: register file, immediate generation, EX/WB
// forwarding, load-use stall and WB re-snoop of a held output.
// The interface must be instantiated with RIDX = $clog2(NREG).
module operand_fetch #(
  parameter int          XLEN     = 32,
  parameter int          NREG     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0033
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);
  localparam int RIDX = $clog2(NREG);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [XLEN-1:0]            rf_q [NREG];
  logic [6:0]                 opcode;
  logic [1:0]                 src_use;
  logic [1:0][4:0]            src_fld;
  logic [1:0][RIDX-1:0]       src_idx;
  logic [1:0][XLEN-1:0]       opnd;
  logic [1:0]                 haz_src;
  logic                       hazard;
  logic                       capture;
  logic [31:0]                imm32;
  logic [XLEN-1:0]            imm_x;

  logic                       valid_q, valid_d;
  logic [31:0]                insn_q, insn_d;
  logic [XLEN-1:0]            pc_q, pc_d;
  logic [1:0][XLEN-1:0]       opnd_q, opnd_d;
  logic [XLEN-1:0]            imm_q, imm_d;
  logic [1:0][RIDX-1:0]       hidx_q, hidx_d;
  logic [31:0]                cnt_q, cnt_d;

  assign opcode = bus.in_insn[6:0];

  // Which source fields the incoming opcode actually reads.
  always_comb begin
    src_use = 2'b00;
    case (opcode)
      OP_R, OP_S, OP_B:     src_use = 2'b11;
      OP_I, OP_L, OP_JALR:  src_use = 2'b01;
      default:              src_use = 2'b00;
    endcase
  end

  // Effective source index (0 when unused or out of range), forwarded
  // operand value and per-source load-use hazard.
  always_comb begin
    src_fld[0] = bus.in_insn[19:15];
    src_fld[1] = bus.in_insn[24:20];
    src_idx    = '0;
    opnd       = '0;
    haz_src    = '0;
    for (int s = 0; s < 2; s++) begin
      if (src_use[s] && ({27'd0, src_fld[s]} < 32'(NREG)))
        src_idx[s] = RIDX'(src_fld[s]);
      if (src_idx[s] == '0)
        opnd[s] = '0;
      else if (bus.ex_wen && bus.ex_rd == src_idx[s] && !bus.ex_is_load)
        opnd[s] = bus.ex_val;
      else if (bus.wb_wen && bus.wb_rd == src_idx[s])
        opnd[s] = bus.wb_val;  // also covers same-cycle write-through
      else
        opnd[s] = rf_q[src_idx[s]];
      haz_src[s] = bus.ex_wen && bus.ex_is_load && (bus.ex_rd != '0) &&
                   (bus.ex_rd == src_idx[s]);
    end
  end

  assign hazard       = |haz_src;
  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush && !rst;
  assign capture      = bus.in_valid && bus.in_ready;

  // Immediate decode, built as 32 bits then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_I, OP_L, OP_JALR: imm32 = {{20{bus.in_insn[31]}}, bus.in_insn[31:20]};
      OP_S:                imm32 = {{20{bus.in_insn[31]}}, bus.in_insn[31:25], bus.in_insn[11:7]};
      OP_B:                imm32 = {{19{bus.in_insn[31]}}, bus.in_insn[31], bus.in_insn[7],
                                    bus.in_insn[30:25], bus.in_insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC:    imm32 = {bus.in_insn[31:12], 12'b0};
      OP_JAL:              imm32 = {{11{bus.in_insn[31]}}, bus.in_insn[31], bus.in_insn[19:12],
                                    bus.in_insn[20], bus.in_insn[30:21], 1'b0};
      default:             imm32 = '0;
    endcase
    imm_x = XLEN'(signed'(imm32));
  end

  // Output register next state: flush > capture > drain > hold/re-snoop.
  always_comb begin
    valid_d = valid_q;
    insn_d  = insn_q;
    pc_d    = pc_q;
    opnd_d  = opnd_q;
    imm_d   = imm_q;
    hidx_d  = hidx_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
    end else begin
      if (capture) begin
        valid_d = 1'b1;
        insn_d  = bus.in_insn;
        pc_d    = bus.in_pc;
        opnd_d  = opnd;
        imm_d   = imm_x;
        hidx_d  = src_idx;
      end else if (valid_q && bus.out_ready) begin
        valid_d = 1'b0;
        insn_d  = NOP_INSN;
      end else if (valid_q) begin
        // Held: a load that was in EX may land in WB now; EX is ignored.
        for (int s = 0; s < 2; s++)
          if (hidx_q[s] != '0 && bus.wb_wen && bus.wb_rd == hidx_q[s])
            opnd_d[s] = bus.wb_val;
      end
      if (bus.in_valid && hazard && cnt_q != '1)
        cnt_d = cnt_q + 32'd1;
    end
  end

  // Output/stall state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      insn_q  <= NOP_INSN;
      pc_q    <= '0;
      opnd_q  <= '0;
      imm_q   <= '0;
      hidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      opnd_q  <= opnd_d;
      imm_q   <= imm_d;
      hidx_q  <= hidx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register file write; flush does not block writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else if (bus.wb_wen && bus.wb_rd != '0) begin
      rf_q[bus.wb_rd] <= bus.wb_val;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_insn    = insn_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rs1_val = opnd_q[0];
  assign bus.out_rs2_val = opnd_q[1];
  assign bus.out_imm     = imm_q;
  assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run
// against a behavioural model of the stage.
module tb_operand_fetch;
  localparam logic [31:0] NOP = 32'h0000_0033;
  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
                                      7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F};

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(32), .RIDX(5)) b();
  operand_fetch_if #(.XLEN(32), .RIDX(4)) b16();

  operand_fetch #(.XLEN(32), .NREG(32), .NOP_INSN(NOP)) dut   (.clk(clk), .rst(rst), .bus(b));
  operand_fetch #(.XLEN(32), .NREG(16), .NOP_INSN(NOP)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  function automatic bit uses1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Immediate via arithmetic shifts of the signed instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int s;
    s = i;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) << 5) | 32'(i[11:7]);
      7'h63: return 32'((s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    b.flush = 0; b.in_valid = 0; b.in_insn = NOP; b.in_pc = 0;
    b.ex_wen = 0; b.ex_rd = 0; b.ex_val = 0; b.ex_is_load = 0;
    b.wb_wen = 0; b.wb_rd = 0; b.wb_val = 0; b.out_ready = 1;
    b16.flush = 0; b16.in_valid = 0; b16.in_insn = NOP; b16.in_pc = 0;
    b16.ex_wen = 0; b16.ex_rd = 0; b16.ex_val = 0; b16.ex_is_load = 0;
    b16.wb_wen = 0; b16.wb_rd = 0; b16.wb_val = 0; b16.out_ready = 1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; b.in_valid = 1; b.in_insn = 32'h0002_8333; #1;
    n_chk++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", b.in_ready); end
    step(); rst = 0; b.in_valid = 0; #1;
    n_chk++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b.out_valid); end
    n_chk++; if (b.out_insn !== NOP) begin n_fail++; $display("FAIL reset_insn got %h want %h", b.out_insn, NOP); end
    n_chk++; if ({b.out_pc, b.out_rs1_val, b.out_rs2_val, b.out_imm} !== 128'd0) begin n_fail++; $display("FAIL reset_data got %h %h %h %h want 0", b.out_pc, b.out_rs1_val, b.out_rs2_val, b.out_imm); end
    n_chk++; if (b.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", b.stall_cnt); end
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", b.in_ready); end
  endtask

  task automatic test_fwd_rf();
    b.wb_wen = 1; b.wb_rd = 5; b.wb_val = 32'h1234; step();
    b.wb_wen = 0; b.in_valid = 1; b.in_insn = 32'h0002_8333; b.in_pc = 32'h100; step();
    b.in_valid = 0;
    n_chk++; if (b.out_valid !== 1'b1) begin n_fail++; $display("FAIL rf_valid got %b want 1", b.out_valid); end
    n_chk++; if (b.out_rs1_val !== 32'h1234) begin n_fail++; $display("FAIL rf_rs1 got %h want 1234", b.out_rs1_val); end
    n_chk++; if (b.out_rs2_val !== 32'h0 || b.out_imm !== 32'h0) begin n_fail++; $display("FAIL rf_rs2_imm got %h %h want 0 0", b.out_rs2_val, b.out_imm); end
    n_chk++; if (b.out_pc !== 32'h100 || b.out_insn !== 32'h0002_8333) begin n_fail++; $display("FAIL rf_pc_insn got %h %h", b.out_pc, b.out_insn); end
    step();
    n_chk++; if (b.out_valid !== 1'b0 || b.out_insn !== NOP) begin n_fail++; $display("FAIL drain got %b %h want 0 %h", b.out_valid, b.out_insn, NOP); end
  endtask

  task automatic test_fwd_priority();
    b.ex_wen = 1; b.ex_rd = 5; b.ex_val = 32'hAAAA; b.ex_is_load = 0;
    b.wb_wen = 1; b.wb_rd = 5; b.wb_val = 32'hBBBB;
    b.in_valid = 1; b.in_insn = 32'hFFF2_8393; step();
    idle();
    n_chk++; if (b.out_rs1_val !== 32'hAAAA) begin n_fail++; $display("FAIL prio_rs1 got %h want aaaa", b.out_rs1_val); end
    n_chk++; if (b.out_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL prio_imm got %h want ffffffff", b.out_imm); end
    step();
  endtask

  task automatic test_load_use();
    b.ex_wen = 1; b.ex_is_load = 1; b.ex_rd = 5; b.ex_val = 32'hDEAD;
    b.in_valid = 1; b.in_insn = 32'h0051_2423;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready cyc%0d got %b want 0", k, b.in_ready); end
      step();
    end
    n_chk++; if (b.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_stall got %0d want 2", b.stall_cnt); end
    n_chk++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_nocap got %b want 0", b.out_valid); end
    b.ex_wen = 0; b.ex_is_load = 0; b.wb_wen = 1; b.wb_rd = 5; b.wb_val = 32'h55; #1;
    n_chk++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b want 1", b.in_ready); end
    step(); idle();
    n_chk++; if (b.out_valid !== 1'b1 || b.out_rs2_val !== 32'h55) begin n_fail++; $display("FAIL lu_rs2 got %b %h want 1 55", b.out_valid, b.out_rs2_val); end
    n_chk++; if (b.out_imm !== 32'd8 || b.out_rs1_val !== 32'd0) begin n_fail++; $display("FAIL lu_imm_rs1 got %h %h want 8 0", b.out_imm, b.out_rs1_val); end
    n_chk++; if (b.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_stall_hold got %0d want 2", b.stall_cnt); end
    step();
  endtask

  task automatic test_hold_snoop();
    b.in_valid = 1; b.in_insn = 32'h0002_8333; b.out_ready = 0; step();
    b.in_valid = 0; b.wb_wen = 1; b.wb_rd = 5; b.wb_val = 32'h99;
    b.ex_wen = 1; b.ex_rd = 5; b.ex_val = 32'h77; #1;
    n_chk++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b want 0", b.in_ready); end
    n_chk++; if (b.out_rs1_val !== 32'h55) begin n_fail++; $display("FAIL hold_cap got %h want 55", b.out_rs1_val); end
    step(); b.wb_wen = 0; b.ex_wen = 0;
    n_chk++; if (b.out_valid !== 1'b1 || b.out_rs1_val !== 32'h99) begin n_fail++; $display("FAIL hold_snoop got %b %h want 1 99", b.out_valid, b.out_rs1_val); end
    b.out_ready = 1; step();
    n_chk++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain got %b want 0", b.out_valid); end
  endtask

  task automatic test_flush();
    b.in_valid = 1; b.in_insn = 32'h0002_8333; b.out_ready = 0; step();
    b.flush = 1; b.in_insn = 32'h1234_50B7; b.wb_wen = 1; b.wb_rd = 7; b.wb_val = 32'h77; #1;
    n_chk++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b want 0", b.in_ready); end
    step();
    n_chk++; if (b.out_valid !== 1'b0 || b.out_insn !== NOP) begin n_fail++; $display("FAIL fl_kill got %b %h want 0 %h", b.out_valid, b.out_insn, NOP); end
    b.flush = 0; b.wb_wen = 0; b.out_ready = 1; step();
    n_chk++; if (b.out_valid !== 1'b1 || b.out_imm !== 32'h1234_5000) begin n_fail++; $display("FAIL fl_lui got %b %h want 1 12345000", b.out_valid, b.out_imm); end
    b.in_insn = 32'h0003_8333; step();
    n_chk++; if (b.out_rs1_val !== 32'h77) begin n_fail++; $display("FAIL fl_rfwrite got %h want 77", b.out_rs1_val); end
    idle(); step();
  endtask

  task automatic test_nreg16();
    b16.wb_wen = 1; b16.wb_rd = 4'd1; b16.wb_val = 32'hDEAD; step();
    b16.wb_rd = 4'd0; b16.wb_val = 32'h5; b16.in_valid = 1; b16.in_insn = 32'h0008_80B3; step();
    n_chk++; if (b16.out_valid !== 1'b1 || b16.out_rs1_val !== 32'd0) begin n_fail++; $display("FAIL n16_range got %b %h want 1 0", b16.out_valid, b16.out_rs1_val); end
    b16.in_insn = 32'h0010_0133; step();
    n_chk++; if (b16.out_rs1_val !== 32'd0) begin n_fail++; $display("FAIL n16_x0 got %h want 0", b16.out_rs1_val); end
    n_chk++; if (b16.out_rs2_val !== 32'hDEAD) begin n_fail++; $display("FAIL n16_x1 got %h want dead", b16.out_rs2_val); end
    idle(); step();
  endtask

  task automatic test_random();
    logic [31:0] regs [32];
    logic        ev;
    logic [31:0] ei, epc, eimm, ecnt, insn;
    logic [31:0] eop [2];
    logic [31:0] v [2];
    int          h [2];
    int          eff [2];
    bit          hz, rdy;
    idle(); rst = 1; step(); rst = 0;
    for (int r = 0; r < 32; r++) regs[r] = 0;
    ev = 0; ei = NOP; epc = 0; eimm = 0; ecnt = 0; eop[0] = 0; eop[1] = 0; h[0] = 0; h[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      insn = $urandom;
      insn[6:0] = OPS[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) != 0) begin
        insn[19:15] = 5'($urandom_range(0, 7));
        insn[24:20] = 5'($urandom_range(0, 7));
      end
      b.in_insn = insn; b.in_pc = $urandom; b.in_valid = ($urandom_range(0, 3) != 0);
      b.out_ready = ($urandom_range(0, 3) != 0); b.flush = ($urandom_range(0, 15) == 0);
      b.ex_wen = ($urandom_range(0, 3) != 0); b.ex_rd = 5'($urandom_range(0, 7));
      b.ex_val = $urandom; b.ex_is_load = ($urandom_range(0, 3) == 0);
      b.wb_wen = ($urandom_range(0, 3) != 0); b.wb_rd = 5'($urandom_range(0, 7)); b.wb_val = $urandom;
      #1;
      hz = 0;
      eff[0] = uses1(insn[6:0]) ? int'(insn[19:15]) : 0;
      eff[1] = uses2(insn[6:0]) ? int'(insn[24:20]) : 0;
      for (int s = 0; s < 2; s++) begin
        if (eff[s] == 0) v[s] = 0;
        else if (b.ex_wen && int'(b.ex_rd) == eff[s] && !b.ex_is_load) v[s] = b.ex_val;
        else if (b.wb_wen && int'(b.wb_rd) == eff[s]) v[s] = b.wb_val;
        else v[s] = regs[eff[s]];
        if (b.ex_wen && b.ex_is_load && eff[s] != 0 && int'(b.ex_rd) == eff[s]) hz = 1;
      end
      rdy = (!ev || b.out_ready) && !hz && !b.flush;
      n_chk++; if (b.in_ready !== rdy) begin n_fail++; $display("FAIL rnd_ready cyc%0d got %b want %b", c, b.in_ready, rdy); end
      if (b.flush) begin
        ev = 0; ei = NOP;
      end else if (b.in_valid && rdy) begin
        ev = 1; ei = insn; epc = b.in_pc; eop[0] = v[0]; eop[1] = v[1];
        eimm = ref_imm(insn); h[0] = eff[0]; h[1] = eff[1];
      end else if (ev && b.out_ready) begin
        ev = 0; ei = NOP;
      end else if (ev) begin
        for (int s = 0; s < 2; s++)
          if (h[s] != 0 && b.wb_wen && int'(b.wb_rd) == h[s]) eop[s] = b.wb_val;
      end
      if (!b.flush && b.in_valid && hz && ecnt != 32'hFFFF_FFFF) ecnt++;
      if (b.wb_wen && b.wb_rd != 0) regs[b.wb_rd] = b.wb_val;
      step();
      n_chk++; if (b.out_valid !== ev || b.out_insn !== ei) begin n_fail++; $display("FAIL rnd_vi cyc%0d got %b %h want %b %h", c, b.out_valid, b.out_insn, ev, ei); end
      n_chk++; if (b.stall_cnt !== ecnt) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %0d want %0d", c, b.stall_cnt, ecnt); end
      if (ev) begin
        n_chk++; if (b.out_pc !== epc || b.out_imm !== eimm) begin n_fail++; $display("FAIL rnd_pc_imm cyc%0d got %h %h want %h %h", c, b.out_pc, b.out_imm, epc, eimm); end
        n_chk++; if (b.out_rs1_val !== eop[0] || b.out_rs2_val !== eop[1]) begin n_fail++; $display("FAIL rnd_ops cyc%0d got %h %h want %h %h", c, b.out_rs1_val, b.out_rs2_val, eop[0], eop[1]); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fwd_rf();
    test_fwd_priority();
    test_load_use();
    test_hold_snoop();
    test_flush();
    test_nreg16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
